// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline: register RAW
// hazards from Tuse/Tnew, a multiply/divide busy counter and a stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_start,
    input  logic        E_div,
    output logic        stall,
    output logic        mdu_busy,
    output logic [3:0]  busy_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    logic [4:0]  src_addr [2];
    logic [1:0]  src_tuse [2];
    logic [1:0]  src_haz;
    logic        md_haz;

    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign src_addr[0] = D_rs_addr;
    assign src_addr[1] = D_rt_addr;
    assign src_tuse[0] = D_rs_tuse;
    assign src_tuse[1] = D_rt_tuse;

    // One RAW checker per source operand; tuse == 3 marks the operand unused.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic e_hit;
            logic m_hit;
            assign e_hit = (src_addr[gi] == E_wa) && (src_tuse[gi] < E_tnew);
            assign m_hit = (src_addr[gi] == M_wa) && (src_tuse[gi] < M_tnew);
            assign src_haz[gi] = (src_addr[gi] != 5'd0) && (src_tuse[gi] != 2'd3)
                                 && (e_hit || m_hit);
        end
    endgenerate

    assign mdu_busy = (busy_cnt_q != 4'd0);
    assign md_haz   = D_md && (mdu_busy || E_start);
    assign stall    = !Req && (|src_haz || md_haz);

    always_comb begin
        busy_cnt_d  = busy_cnt_q;
        stall_cnt_d = stall_cnt_q;
        // A killed start never loads, but an op already in flight keeps counting.
        if (E_start && !Req) begin
            busy_cnt_d = E_div ? DIV_LOAD : MULT_LOAD;
        end else if (busy_cnt_q != 4'd0) begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_cnt_q  <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            busy_cnt_q  <= busy_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_cnt  = busy_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        rst, Req, D_md, E_start, E_div;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        stall, mdu_busy;
    logic [3:0]  busy_cnt;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst(rst), .Req(Req),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_md(D_md),
        .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
        .E_start(E_start), .E_div(E_div),
        .stall(stall), .mdu_busy(mdu_busy), .busy_cnt(busy_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic   stall;
        int     busy;
        longint sc;
    } exp_t;

    exp_t   sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;

    // Reference state: remaining MDU cycles and the saturating stall tally.
    int     m_busy = 0;
    longint m_sc   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit raw(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 0 || tuse == 3) return 1'b0;
        return (a == E_wa && tuse < E_tnew) || (a == M_wa && tuse < M_tnew);
    endfunction

    function automatic logic model_stall();
        bit md;
        md = D_md && (m_busy > 0 || E_start);
        return !Req && (raw(D_rs_addr, D_rs_tuse) || raw(D_rt_addr, D_rt_tuse) || md);
    endfunction

    // Issue the current inputs for one cycle; record what the DUT must show.
    task automatic step(input bit chk);
        exp_t e;
        logic s;
        s = model_stall();
        if (chk) begin
            e.stall = s; e.busy = m_busy; e.sc = m_sc;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!rst) begin
            m_busy = 0;
            m_sc   = 0;
        end else begin
            if (E_start && !Req) m_busy = E_div ? DIV_CYC : MULT_CYC;
            else if (m_busy > 0) m_busy = m_busy - 1;
            if (s && m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1; Req = 0; D_md = 0; E_start = 0; E_div = 0;
        D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 3; D_rt_tuse = 3;
        E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall", longint'(stall), longint'(e.stall));
            check("busy_cnt", longint'(busy_cnt), longint'(e.busy));
            check("mdu_busy", longint'(mdu_busy), longint'(e.busy != 0));
            check("stall_cnt", longint'(stall_cnt), e.sc);
        end
    end

    initial begin
        idle_inputs();
        // Reset held two cycles against an MDU start and a load-use hazard.
        rst = 0; E_start = 1; D_md = 1; E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1;
        step(0);
        step(1);
        idle_inputs();
        step(1);

        // Load-use then its resolutions.
        E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1; step(1);
        E_tnew = 1; step(1);
        E_tnew = 2; D_rs_addr = 0; step(1);
        idle_inputs(); M_wa = 9; M_tnew = 1; D_rt_addr = 9; D_rt_tuse = 0; step(1);
        idle_inputs(); step(1);

        // Multiply then divide with the dependent MDU op waiting in D.
        for (int k = 0; k < 2; k++) begin
            idle_inputs(); D_md = 1; E_start = 1; E_div = (k == 1);
            step(1);
            E_start = 0;
            for (int i = 0; i < 12; i++) step(1);
        end

        // Req priority over every hazard source and over an MDU start.
        idle_inputs(); Req = 1; D_md = 1; E_start = 1;
        E_wa = 4; E_tnew = 2; D_rs_addr = 4; D_rs_tuse = 0; step(1);
        idle_inputs(); step(1);
        E_start = 1; step(1);
        E_start = 0; step(1); step(1);
        Req = 1; for (int i = 0; i < 4; i++) step(1);

        // Twenty held stall cycles.
        idle_inputs(); E_wa = 3; E_tnew = 2; D_rt_addr = 3; D_rt_tuse = 0;
        for (int i = 0; i < 20; i++) step(1);
        idle_inputs(); step(1);

        // Saturation from a deposited near-max value.
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_sc = 64'hFFFF_FFFE;
        E_wa = 3; E_tnew = 2; D_rt_addr = 3; D_rt_tuse = 0;
        for (int i = 0; i < 3; i++) step(1);
        idle_inputs(); step(1);

        // Reset in the middle of a divide, then an MDU op issues freely.
        E_start = 1; E_div = 1; step(1);
        E_start = 0; E_div = 0; step(1); step(1); step(1);
        rst = 0; step(1);
        rst = 1; D_md = 1; step(1); step(1);

        // Randomized traffic honouring the no-restart-while-busy contract.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) != 0);
            Req       = ($urandom_range(0, 9) == 0);
            D_md      = ($urandom_range(0, 3) == 0);
            D_rs_addr = 5'($urandom_range(0, 3));
            D_rt_addr = 5'($urandom_range(0, 3));
            D_rs_tuse = 2'($urandom_range(0, 3));
            D_rt_tuse = 2'($urandom_range(0, 3));
            E_wa      = 5'($urandom_range(0, 3));
            M_wa      = 5'($urandom_range(0, 3));
            E_tnew    = 2'($urandom_range(0, 3));
            M_tnew    = 2'($urandom_range(0, 3));
            E_start   = (m_busy == 0) && ($urandom_range(0, 5) == 0);
            E_div     = 1'($urandom_range(0, 1));
            step(1);
        end

        idle_inputs();
        @(negedge clk);
        #1;
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. It decides each cycle whether the D/E pipeline register loads a bubble (stall) and whether F/D holds. It combines register read-after-write hazards, computed from pre-decoded Tuse/Tnew values, with a multi-cycle multiply/divide busy counter. It also carries a saturating stall-cycle performance counter. The exception request `Req` has absolute priority over stall.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles loaded for mult/multu
- DIV_CYC, 10, busy cycles loaded for div/divu

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- Req  in  1  exception/interrupt flush request from CP0 (same cycle as D/E flush)
- D_rs_addr  in  5  rs index of instruction in D
- D_rt_addr  in  5  rt index of instruction in D
- D_rs_tuse  in  2  cycles until D needs rs (0,1,2); 3 = rs unused
- D_rt_tuse  in  2  cycles until D needs rt (0,1,2); 3 = rt unused
- D_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_wa  in  5  destination register of instruction in E (0 = none)
- E_tnew  in  2  cycles until E result is available
- M_wa  in  5  destination register of instruction in M
- M_tnew  in  2  cycles until M result is available
- E_start  in  1  instruction in E is mult/multu/div/divu (start this cycle)
- E_div  in  1  qualifies E_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  combinational; F/D hold, D/E insert bubble
- mdu_busy  out  1  registered busy-counter-nonzero flag
- busy_cnt  out  4  remaining MDU busy cycles
- stall_cnt  out  32  saturating count of cycles in which stall was asserted

## Operation
- rs hazard: D_rs_addr != 0 and D_rs_tuse != 3, plus one of:
  - D_rs_addr == E_wa and D_rs_tuse < E_tnew
  - D_rs_addr == M_wa and D_rs_tuse < M_tnew
- rt hazard: same conditions using the rt inputs.
- md hazard: D_md & (mdu_busy | E_start).
- stall = ~Req & (rs_haz | rt_haz | md_haz). Req forces stall = 0, so the flush wins.
- Busy counter:
  - Load: if E_start & ~Req, busy_cnt <= E_div ? DIV_CYC : MULT_CYC.
  - Decrement: else if busy_cnt != 0, busy_cnt <= busy_cnt - 1.
  - mdu_busy = (busy_cnt != 0). It is derived from the register and is not a separate flop.
- A start attempt killed by Req does not load the counter. An operation already in flight continues counting through Req, because HI/LO completion is not cancelled.
- A new E_start while busy_cnt != 0 reloads the counter. Bench contract: this cannot occur, because md hazard stalls any MDU instruction in D.
- stall_cnt increments by 1 each cycle stall = 1 and holds at 32'hFFFF_FFFF (saturates, never wraps).
- Width rules: busy_cnt is 4 bits, so MULT_CYC and DIV_CYC must be ≤ 15. Tuse/Tnew comparisons are unsigned 2-bit.

## Timing
- Reset (rst = 0 at a rising edge): busy_cnt = 0, mdu_busy = 0, stall_cnt = 0. stall then depends only on the register-hazard inputs.
- Reset has priority over E_start, Req and counting. A reset asserted mid-division clears busy_cnt in that cycle.
- stall has zero latency: it is combinational from the inputs and busy_cnt.
- With E_start at edge N, busy_cnt = MULT_CYC after edge N. mdu_busy stays high for exactly MULT_CYC cycles (DIV_CYC for a divide).
- md stall covers the E_start cycle plus the MULT_CYC/DIV_CYC busy cycles. The MDU instruction in D issues in the first cycle with busy_cnt == 0 and E_start == 0.
- stall_cnt reflects a stall cycle one edge later.

## Test plan
- rst = 0 for 2 cycles, with E_start = 1 and stall-inducing inputs applied -> busy_cnt = 0 and stall_cnt = 0 after release.
- Load-use: E_wa = 8, E_tnew = 2, D_rs_addr = 8, D_rs_tuse = 1 -> stall = 1. Change to E_tnew = 1 -> stall = 0. Change to D_rs_addr = 0 -> stall = 0.
- Multiply: E_start = 1, E_div = 0, D_md = 1 -> stall for 6 consecutive cycles (start + 5), busy_cnt sequence 5,4,3,2,1,0, stall = 0 in the 7th cycle. Repeat with E_div = 1 -> 11 stall cycles.
- Req priority: all hazard inputs active with Req = 1 -> stall = 0. Req with E_start -> busy_cnt stays 0. Req with busy_cnt = 3 -> counts 2,1,0.
- stall_cnt: hold stall = 1 for 20 cycles -> stall_cnt = 20. Force the counter near saturation (preload via hierarchical deposit at 32'hFFFF_FFFE) and stall for 3 cycles -> stall_cnt = 32'hFFFF_FFFF.
- Reset mid-divide: rst = 0 when busy_cnt = 7 -> busy_cnt = 0 next cycle and a D_md instruction issues without stall.
